// File: rtl/redux_pkg.sv
// Shared REDUX-V definitions: opcodes, ULA op codes, controller state and mux select codes.
package redux_pkg;

  localparam logic [3:0] OPC_BRZR = 4'h0;
  localparam logic [3:0] OPC_JI   = 4'h1;
  localparam logic [3:0] OPC_LD   = 4'h2;
  localparam logic [3:0] OPC_ST   = 4'h3;
  localparam logic [3:0] OPC_ADDI = 4'h4;
  localparam logic [3:0] OPC_HALT = 4'h7;

  localparam logic [2:0] ULA_NOT = 3'b000;
  localparam logic [2:0] ULA_AND = 3'b001;
  localparam logic [2:0] ULA_OR  = 3'b010;
  localparam logic [2:0] ULA_XOR = 3'b011;
  localparam logic [2:0] ULA_ADD = 3'b100;
  localparam logic [2:0] ULA_SUB = 3'b101;
  localparam logic [2:0] ULA_SHL = 3'b110;
  localparam logic [2:0] ULA_SHR = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    PC_INC = 2'b00,
    PC_REG = 2'b01,
    PC_REL = 2'b10
  } pc_src_t;

  typedef enum logic {
    REG_ULA = 1'b0,
    REG_MEM = 1'b1
  } reg_src_t;

endpackage

// File: rtl/control_decode.sv
// Combinational IR decoder: instruction class flags and datapath control fields.
import redux_pkg::*;

module control_decode #(
  parameter int BITS = 8,
  parameter int OP   = 3
) (
  input  logic [BITS-1:0] ir,
  output logic            is_alu,
  output logic            is_brzr,
  output logic            is_ji,
  output logic            is_ld,
  output logic            is_st,
  output logic            is_addi,
  output logic            is_halt,
  output logic [OP-1:0]   alu_op,
  output logic            alu_b_sel,
  output logic [1:0]      ra,
  output logic [1:0]      rb,
  output logic [3:0]      imm
);

  logic [3:0] opcode;

  always_comb begin
    opcode    = ir[7:4];
    is_alu    = opcode[3];
    is_brzr   = (opcode == OPC_BRZR);
    is_ji     = (opcode == OPC_JI);
    is_ld     = (opcode == OPC_LD);
    is_st     = (opcode == OPC_ST);
    is_addi   = (opcode == OPC_ADDI);
    is_halt   = (opcode == OPC_HALT);
    alu_b_sel = is_addi;
    ra        = ir[3:2];
    rb        = ir[1:0];
    imm       = ir[3:0];
    alu_op    = '0;
    if (is_alu) begin
      alu_op = OP'(opcode[2:0]);
    end else if (is_addi) begin
      alu_op = OP'(ULA_ADD);
    end
  end

endmodule

// File: rtl/control_unit.sv
// REDUX-V multi-cycle controller: fetch/decode/execute/memory sequencing and datapath strobes.
import redux_pkg::*;

module control_unit #(
  parameter int BITS = 8,
  parameter int OP   = 3
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [BITS-1:0] instr_in,
  input  logic            mem_ready_in,
  input  logic            zero_in,
  output logic            mem_req_out,
  output logic            mem_we_out,
  output logic            mem_addr_sel_out,
  output logic            ir_we_out,
  output logic            pc_we_out,
  output logic [1:0]      pc_src_out,
  output logic            reg_we_out,
  output logic            reg_src_out,
  output logic            alu_b_sel_out,
  output logic [OP-1:0]   alu_op_out,
  output logic [1:0]      ra_out,
  output logic [1:0]      rb_out,
  output logic [3:0]      imm_out,
  output logic            halted_out
);

  state_t          state, state_next;
  logic [BITS-1:0] ir;

  logic            is_alu, is_brzr, is_ji, is_ld, is_st, is_addi, is_halt;
  logic [OP-1:0]   alu_op;
  logic            alu_b_sel;
  logic [1:0]      ra, rb;
  logic [3:0]      imm;

  logic            mem_req, mem_we, mem_addr_sel, ir_we, pc_we, reg_we, halted;
  pc_src_t         pc_src;
  reg_src_t        reg_src;

  control_decode #(
    .BITS(BITS),
    .OP  (OP)
  ) u_decode (
    .ir       (ir),
    .is_alu   (is_alu),
    .is_brzr  (is_brzr),
    .is_ji    (is_ji),
    .is_ld    (is_ld),
    .is_st    (is_st),
    .is_addi  (is_addi),
    .is_halt  (is_halt),
    .alu_op   (alu_op),
    .alu_b_sel(alu_b_sel),
    .ra       (ra),
    .rb       (rb),
    .imm      (imm)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= S_FETCH;
      ir    <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && mem_ready_in) begin
        ir <= instr_in;
      end
    end
  end

  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_INC;
    reg_we       = 1'b0;
    reg_src      = REG_ULA;
    halted       = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready_in) begin
          ir_we      = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_ld || is_st) begin
          state_next = S_MEMORY;
        end else if (is_halt) begin
          state_next = S_HALT;
        end else begin
          state_next = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        pc_we      = 1'b1;
        reg_we     = is_alu || is_addi;
        state_next = S_FETCH;
        if (is_brzr) begin
          pc_src = zero_in ? PC_REG : PC_INC;
        end else if (is_ji) begin
          pc_src = PC_REL;
        end
      end
      S_MEMORY: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = is_st;
        reg_src      = is_ld ? REG_MEM : REG_ULA;
        if (mem_ready_in) begin
          pc_we      = 1'b1;
          reg_we     = is_ld;
          state_next = S_FETCH;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Every output, including the IR-derived fields, reads as zero while reset is held.
  always_comb begin
    mem_req_out      = 1'b0;
    mem_we_out       = 1'b0;
    mem_addr_sel_out = 1'b0;
    ir_we_out        = 1'b0;
    pc_we_out        = 1'b0;
    pc_src_out       = '0;
    reg_we_out       = 1'b0;
    reg_src_out      = 1'b0;
    alu_b_sel_out    = 1'b0;
    alu_op_out       = '0;
    ra_out           = '0;
    rb_out           = '0;
    imm_out          = '0;
    halted_out       = 1'b0;
    if (!rst_in) begin
      mem_req_out      = mem_req;
      mem_we_out       = mem_we;
      mem_addr_sel_out = mem_addr_sel;
      ir_we_out        = ir_we;
      pc_we_out        = pc_we;
      pc_src_out       = pc_src;
      reg_we_out       = reg_we;
      reg_src_out      = reg_src;
      alu_b_sel_out    = alu_b_sel;
      alu_op_out       = alu_op;
      ra_out           = ra;
      rb_out           = rb;
      imm_out          = imm;
      halted_out       = halted;
    end
  end

endmodule
